// File: rtl/circular_shift_register.sv
// Free-running rotating bank of SIZE entries of WIDTH bits, loaded with the
// index pattern on a synchronous active-low reset and rotated by one entry per clock.
module circular_shift_register #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 16,
  parameter bit DIR   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [WIDTH*SIZE-1:0]   reg_out
);

  // Entry i holds i truncated to WIDTH bits; wraps when SIZE exceeds 2^WIDTH.
  function automatic logic [WIDTH*SIZE-1:0] reset_image();
    logic [WIDTH*SIZE-1:0] img;
    img = '0;
    for (int i = 0; i < SIZE; i++) begin
      img[i*WIDTH +: WIDTH] = WIDTH'(i);
    end
    return img;
  endfunction

  localparam logic [WIDTH*SIZE-1:0] RESET_IMAGE = reset_image();

  logic [WIDTH*SIZE-1:0] bank_r;
  logic [WIDTH*SIZE-1:0] rotated_s;

  // Rotation is a whole-bank shift by one entry with the leaving entry wrapped around.
  if (DIR == 1'b0) begin : g_rot_up
    assign rotated_s = {bank_r[WIDTH*(SIZE-1)-1:0], bank_r[WIDTH*SIZE-1 -: WIDTH]};
  end else begin : g_rot_down
    assign rotated_s = {bank_r[WIDTH-1:0], bank_r[WIDTH*SIZE-1:WIDTH]};
  end

  // Bank register: reset reloads the index pattern, otherwise rotate every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_r <= RESET_IMAGE;
    end else begin
      bank_r <= rotated_s;
    end
  end

  assign reg_out = bank_r;

endmodule

// File: tb/tb_circular_shift_register.sv
// Self-checking bench: three configurations checked against an entry-level
// model through a scoreboard queue, plus constant vectors and corner sequences.
module tb_circular_shift_register;

  localparam logic [127:0] RST_IMG = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] ROT_UP  = 128'h0e0d0c0b0a090807060504030201000f;
  localparam logic [127:0] ROT_DN  = 128'h000f0e0d0c0b0a090807060504030201;

  logic         clk;
  logic         rst_n;
  logic [127:0] out0;
  logic [127:0] out1;
  logic [15:0]  out2;

  int total;
  int passed;

  circular_shift_register dut0 (.clk(clk), .rst_n(rst_n), .reg_out(out0));
  circular_shift_register #(.DIR(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .reg_out(out1));
  circular_shift_register #(.WIDTH(4), .SIZE(4), .DIR(1'b0)) dut2 (.clk(clk), .rst_n(rst_n), .reg_out(out2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] e0;
    logic [127:0] e1;
    logic [15:0]  e2;
  } exp_t;

  typedef struct packed {
    logic         rst;
    logic         chk;
    logic [127:0] e0;
    logic [127:0] e1;
    logic [15:0]  e2;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[9];
  logic [7:0] m0[16];
  logic [7:0] m1[16];
  logic [3:0] m2[4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Entry-level model written directly from the rotation rules.
  task automatic model_step(input logic r);
    logic [7:0] t0[16];
    logic [7:0] t1[16];
    logic [3:0] t2[4];
    t0 = m0; t1 = m1; t2 = m2;
    for (int i = 0; i < 16; i++) begin
      m0[i] = r ? t0[(i + 15) % 16] : 8'(i);
      m1[i] = r ? t1[(i + 1) % 16] : 8'(i);
    end
    for (int i = 0; i < 4; i++) begin
      m2[i] = r ? t2[(i + 3) % 4] : 4'(i);
    end
  endtask

  function automatic exp_t model_pack();
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.e0[i*8 +: 8] = m0[i];
      e.e1[i*8 +: 8] = m1[i];
    end
    for (int i = 0; i < 4; i++) e.e2[i*4 +: 4] = m2[i];
    return e;
  endfunction

  task automatic step(input logic r);
    exp_t e;
    rst_n = r;
    model_step(r);
    sb.push_back(model_pack());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_dir0", out0, e.e0);
    check("sb_dir1", out1, e.e1);
    check("sb_small", {112'd0, out2}, {112'd0, e.e2});
  endtask

  initial begin
    logic [127:0] prev;
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;

    vecs[0] = '{1'b0, 1'b1, RST_IMG, RST_IMG, 16'h3210};
    vecs[1] = '{1'b0, 1'b1, RST_IMG, RST_IMG, 16'h3210};
    vecs[2] = '{1'b1, 1'b1, ROT_UP,  ROT_DN,  16'h2103};
    vecs[3] = '{1'b1, 1'b0, 128'd0,  128'd0,  16'h0000};
    vecs[4] = '{1'b1, 1'b0, 128'd0,  128'd0,  16'h0000};
    vecs[5] = '{1'b1, 1'b0, 128'd0,  128'd0,  16'h0000};
    vecs[6] = '{1'b1, 1'b0, 128'd0,  128'd0,  16'h0000};
    vecs[7] = '{1'b0, 1'b1, RST_IMG, RST_IMG, 16'h3210};
    vecs[8] = '{1'b1, 1'b1, ROT_UP,  ROT_DN,  16'h2103};

    for (int v = 0; v < 9; v++) begin
      step(vecs[v].rst);
      if (vecs[v].chk) begin
        check($sformatf("vec%0d_dir0", v), out0, vecs[v].e0);
        check($sformatf("vec%0d_dir1", v), out1, vecs[v].e1);
        check($sformatf("vec%0d_small", v), {112'd0, out2}, {112'd0, vecs[v].e2});
      end
    end

    // Reset held several edges stays static, then a full period of rotations.
    step(1'b0);
    step(1'b0);
    check("hold_static", out0, RST_IMG);
    prev = out0;
    for (int k = 1; k <= 16; k++) begin
      step(1'b1);
      check($sformatf("changes_%0d", k), {127'd0, out0 !== prev}, 128'd1);
      check($sformatf("entry0_%0d", k), {120'd0, out0[7:0]}, {120'd0, 8'(16 - k)});
      if (k == 4) check("small_period", {112'd0, out2}, {112'd0, 16'h3210});
      prev = out0;
    end
    check("period_dir0", out0, RST_IMG);
    check("period_dir1", out1, RST_IMG);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/circular_shift_register.md
Name: circular_shift_register

Overview:
- Free-running rotating register bank of SIZE entries, each WIDTH bits wide.
- Loads a fixed index pattern on reset, then rotates every entry by one position on every clock.
- Whole bank is exposed as one flat output bus.
- Used as a self-contained pattern/sequence source, for example for display scanning or test stimulus, with no data input.

Parameters:
- WIDTH, 8, bit width of each entry (≥1).
- SIZE, 16, number of entries (≥2; SIZE ≤ 2^WIDTH so reset entries are distinct).
- DIR, 0, rotate direction:
  - 0 = entry i receives entry i-1, and entry 0 receives entry SIZE-1.
  - 1 = entry i receives entry i+1, and entry SIZE-1 receives entry 0.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- reg_out  output  WIDTH*SIZE  flattened bank; entry i occupies bits [i*WIDTH +: WIDTH], entry 0 in the LSBs.

Behaviour:
- Storage: SIZE registers of WIDTH bits. reg_out is a direct, combinational-free view of the registers.
- Reset:
  - Reset is synchronous and active-low: at a rising clk edge with rst_n=0, entry i <= i, truncated to WIDTH bits, for all i.
  - Default reset image (WIDTH=8, SIZE=16): reg_out = 0x0f0e0d0c0b0a09080706050403020100.
  - Before the first reset edge the register contents are undefined; no asynchronous path exists.
- Operation: at every rising clk edge with rst_n=1, all entries rotate by exactly one position per DIR.
  - No enable input; rotation happens every cycle.
  - No data is lost; the value leaving one end wraps to the other end in the same cycle.
- Latency: the rotated value is visible on reg_out immediately after the rising edge, i.e. one register stage.
- Period:
  - The bank returns to the reset image after exactly SIZE rotations.
  - With distinct entries, reg_out differs from its previous value on every rotating cycle.
- Wrap-around, DIR=0: new entry0 = old entry SIZE-1; otherwise entry i = old entry i-1.
- Wrap-around, DIR=1: new entry SIZE-1 = old entry0; otherwise entry i = old entry i+1.
- Reset mid-operation: rst_n=0 at any edge reloads the index pattern, overriding rotation.
  - Rotation resumes on the first edge with rst_n=1.
- Reset held low for multiple cycles: the pattern is held static.
- SIZE > 2^WIDTH: entries are loaded with i mod 2^WIDTH, so duplicates are permitted. Rotation is still performed, but reg_out may repeat across cycles. Designs should keep SIZE ≤ 2^WIDTH.
- Fully synchronous and synthesizable, with no latches. Use parameterised generate or loops for any WIDTH and SIZE.

Test Plan:
- Reset: hold rst_n=0 for 2 edges, default params -> reg_out = 0x0f0e0d0c0b0a09080706050403020100 and stable while rst_n=0.
- Single rotate: release rst_n, one edge, DIR=0 -> reg_out = 0x0e0d0c0b0a090807060504030201000f (entry0=0x0f, entry1=0x00).
- Full cycle: 16 consecutive edges after reset release -> reg_out changes on every edge and equals the reset image after edge 16. Check entry0 follows 0x0f, 0x0e, …, 0x00.
- DIR=1: one edge after reset -> reg_out = 0x000f0e0d0c0b0a090807060504030201 (entry0=0x01, entry15=0x00).
- Mid-run reset: rotate 5 cycles, assert rst_n=0 for 1 edge -> reg_out returns to reset image at that edge. Next edge with rst_n=1 gives the single-rotate value.
- Non-default params: WIDTH=4, SIZE=4, DIR=0 -> reset reg_out = 0x3210, after 1 edge 0x2103, after 4 edges 0x3210.
